cdc_stream_sink: RTL and testbench

//  Destination-domain receiver for the clock_domain_crossing valid/ready stream.

---
 rtl/cdc_stream_sink.sv | 141 ++++++++++++++
 tb/tb_cdc_stream_sink.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_stream_sink.sv
// Destination-domain stream sink for the clock-domain crossing.
// Paces ready_dst, checks an arithmetic sequence, keeps run stats.
module cdc_stream_sink #(
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned CNT_W        = 8,
   parameter int unsigned COUNT        = 10,
   parameter int unsigned START        = 10,
   parameter int unsigned STEP         = 10,
   parameter int unsigned STALL_EVERY  = 3,
   parameter int unsigned STALL_CYCLES = 2
) (
   input  logic              clk_dst,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] data_dst,
   input  logic              valid_dst,
   output logic              ready_dst,
   output logic              busy,
   output logic              done,
   output logic              mismatch,
   output logic [CNT_W-1:0]  rx_count,
   output logic [CNT_W-1:0]  err_count,
   output logic [DATA_W-1:0] last_data,
   output logic [15:0]       checksum
);

   typedef enum logic [1:0] {IDLE, RECV, STALL, DONE} state_t;

   localparam logic [CNT_W-1:0]  CountV  = CNT_W'(COUNT);
   localparam logic [DATA_W-1:0] StartV  = DATA_W'(START);
   localparam logic [DATA_W-1:0] StepV   = DATA_W'(STEP);
   localparam logic [31:0]       EveryV  = 32'(STALL_EVERY);
   localparam logic [31:0]       CyclesV = 32'(STALL_CYCLES);
   localparam bit StallEn = (STALL_EVERY != 0) && (STALL_CYCLES != 0);

   state_t            state_q;
   logic              ready_q, busy_q, done_q, mis_q;
   logic [CNT_W-1:0]  rx_q, err_q;
   logic [DATA_W-1:0] last_q, exp_q;
   logic [15:0]       sum_q;
   logic [31:0]       grp_q, stl_q;

   logic              xfer;
   logic [CNT_W-1:0]  rx_d, err_d;
   logic [DATA_W-1:0] exp_d;
   logic [15:0]       sum_d;
   logic [31:0]       grp_d, stl_d;

   assign xfer  = valid_dst && ready_q && (state_q == RECV);
   assign rx_d  = rx_q + 1'b1;
   assign err_d = (&err_q) ? err_q : err_q + 1'b1;
   assign exp_d = exp_q + StepV;
   assign sum_d = sum_q + 16'(data_dst);
   assign grp_d = grp_q + 32'd1;
   assign stl_d = stl_q + 32'd1;

   // Run FSM: handshake pacing, sequence check and statistics.
   always_ff @(posedge clk_dst or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         mis_q   <= 1'b0;
         rx_q    <= '0;
         err_q   <= '0;
         last_q  <= '0;
         exp_q   <= StartV;
         sum_q   <= '0;
         grp_q   <= '0;
         stl_q   <= '0;
      end else begin
         mis_q <= 1'b0;
         unique case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q <= RECV;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  rx_q    <= '0;
                  err_q   <= '0;
                  sum_q   <= '0;
                  exp_q   <= StartV;
                  grp_q   <= '0;
                  stl_q   <= '0;
               end
            end
            RECV: begin
               if (xfer) begin
                  rx_q   <= rx_d;
                  sum_q  <= sum_d;
                  last_q <= data_dst;
                  exp_q  <= exp_d;
                  if (data_dst != exp_q) begin
                     mis_q <= 1'b1;
                     err_q <= err_d;
                  end
                  if (rx_d == CountV) begin
                     state_q <= DONE;
                     ready_q <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else if (StallEn && grp_d == EveryV) begin
                     state_q <= STALL;
                     ready_q <= 1'b0;
                     grp_q   <= '0;
                     stl_q   <= '0;
                  end else begin
                     grp_q   <= grp_d;
                     ready_q <= 1'b1;
                  end
               end else begin
                  ready_q <= 1'b1;
               end
            end
            STALL: begin
               if (stl_d == CyclesV) begin
                  state_q <= RECV;
                  ready_q <= 1'b1;
               end else begin
                  stl_q <= stl_d;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ready_dst = ready_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign mismatch  = mis_q;
   assign rx_count  = rx_q;
   assign err_count = err_q;
   assign last_data = last_q;
   assign checksum  = sum_q;

endmodule

// File: tb/tb_cdc_stream_sink.sv
// Bench for cdc_stream_sink: queue-based reference model
// compared every cycle, plus literal run-level expectations.
module tb_cdc_stream_sink;

   localparam int CNT = 10;
   localparam int ST  = 10;
   localparam int SP  = 10;
   localparam int SE  = 3;
   localparam int SC  = 2;

   logic       clk_dst = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       valid_dst = 1'b0;
   logic [7:0] data_dst = '0;
   logic       ready_dst, busy, done, mismatch;
   logic [7:0] rx_count, err_count, last_data;
   logic [15:0] checksum;

   logic       start_w = 1'b0;
   logic       valid_w = 1'b0;
   logic [7:0] data_w = '0;
   logic       ready_w, busy_w, done_w, mis_w;
   logic [7:0] rx_w, err_w, last_w;
   logic [15:0] sum_w;

   int total = 0;
   int bad = 0;
   int lowcnt = 0;
   bit cnt_en = 0;

   always #5 clk_dst = ~clk_dst;

   cdc_stream_sink #(
      .DATA_W(8), .CNT_W(8), .COUNT(CNT), .START(ST), .STEP(SP),
      .STALL_EVERY(SE), .STALL_CYCLES(SC)
   ) u_dut (
      .clk_dst(clk_dst), .rst_n(rst_n), .start(start),
      .data_dst(data_dst), .valid_dst(valid_dst),
      .ready_dst(ready_dst), .busy(busy), .done(done),
      .mismatch(mismatch), .rx_count(rx_count),
      .err_count(err_count), .last_data(last_data),
      .checksum(checksum)
   );

   cdc_stream_sink #(
      .DATA_W(8), .CNT_W(8), .COUNT(3), .START(250), .STEP(10),
      .STALL_EVERY(0), .STALL_CYCLES(2)
   ) u_wrap (
      .clk_dst(clk_dst), .rst_n(rst_n), .start(start_w),
      .data_dst(data_w), .valid_dst(valid_w),
      .ready_dst(ready_w), .busy(busy_w), .done(done_w),
      .mismatch(mis_w), .rx_count(rx_w),
      .err_count(err_w), .last_data(last_w),
      .checksum(sum_w)
   );

   task automatic chk(input string name, input longint act,
                      input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   // reference model: accepted words kept in a queue
   int acc[$];
   bit m_run, m_done, m_ready, m_mis;
   int m_stall, m_last;

   function automatic int exp_word(input int i);
      return (ST + i * SP) % 256;
   endfunction

   function automatic int m_err();
      int e = 0;
      foreach (acc[i]) if (acc[i] != exp_word(i)) e++;
      return (e > 255) ? 255 : e;
   endfunction

   function automatic int m_sum();
      int s = 0;
      foreach (acc[i]) s += acc[i];
      return s % 65536;
   endfunction

   always @(posedge clk_dst) begin
      if (!rst_n) begin
         acc.delete();
         m_run = 0; m_done = 0; m_ready = 0; m_mis = 0;
         m_stall = 0; m_last = 0;
      end else begin
         m_mis = 0;
         if (m_run) begin
            if (valid_dst && m_ready) begin
               acc.push_back(int'(data_dst));
               m_last = int'(data_dst);
               if (int'(data_dst) != exp_word(acc.size() - 1))
                  m_mis = 1;
               if (acc.size() == CNT) begin
                  m_run = 0; m_done = 1; m_ready = 0;
               end else if (SE != 0 && SC != 0 &&
                            acc.size() % SE == 0) begin
                  m_stall = SC; m_ready = 0;
               end
            end else if (m_stall > 0) begin
               m_stall--;
               m_ready = (m_stall == 0);
            end
         end else if (start) begin
            acc.delete();
            m_run = 1; m_done = 0; m_ready = 1; m_stall = 0;
         end
      end
      #1;
      chk("ready", ready_dst, m_ready);
      chk("busy", busy, m_run);
      chk("done", done, m_done);
      chk("mismatch", mismatch, m_mis);
      chk("rx_count", rx_count, acc.size());
      chk("err_count", err_count, m_err());
      chk("last_data", last_data, m_last);
      chk("checksum", checksum, m_sum());
   end

   always @(negedge clk_dst)
      if (cnt_en && busy && !ready_dst) lowcnt++;

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk_dst);
      start = 1'b0;
   endtask

   task automatic send(input int d, input int gap);
      int n;
      repeat (gap) begin
         valid_dst = 1'b0;
         data_dst = 8'($urandom);
         @(negedge clk_dst);
      end
      valid_dst = 1'b1;
      data_dst = 8'(d);
      n = 0;
      while (!ready_dst && n < 40) begin
         @(negedge clk_dst);
         n++;
      end
      if (!ready_dst) chk("send_timeout", ready_dst, 1);
      @(negedge clk_dst);
   endtask

   task automatic check_end(input string tag, input int rx,
                            input int er, input int sum);
      chk({tag, "_rx"}, rx_count, rx);
      chk({tag, "_err"}, err_count, er);
      chk({tag, "_sum"}, checksum, sum);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_ready"}, ready_dst, 0);
   endtask

   initial begin
      int ws[3];
      int n;
      int d;
      ws[0] = 250; ws[1] = 4; ws[2] = 14;

      repeat (2) @(negedge clk_dst);
      chk("reset_ready", ready_dst, 0);
      chk("reset_exp_rx", rx_count, 0);
      rst_n = 1'b1;
      @(negedge clk_dst);

      // clean run, valid held high, stall count
      lowcnt = 0;
      cnt_en = 1;
      pulse_start();
      for (int i = 1; i <= 10; i++) send(i * 10, 0);
      cnt_en = 0;
      valid_dst = 1'b0;
      check_end("clean", 10, 0, 16'h0226);
      chk("clean_last", last_data, 100);
      chk("stall_low_cycles", lowcnt, 6);

      // corrupted third word
      pulse_start();
      send(10, $urandom_range(0, 2));
      send(20, $urandom_range(0, 2));
      send(8'h2A, $urandom_range(0, 2));
      chk("mis_pulse", mismatch, 1);
      valid_dst = 1'b0;
      @(negedge clk_dst);
      chk("mis_clear", mismatch, 0);
      for (int i = 4; i <= 10; i++) send(i * 10, $urandom_range(0, 2));
      valid_dst = 1'b0;
      @(negedge clk_dst);
      check_end("corrupt", 10, 1, 16'h0226 - 30 + 42);

      // async reset mid-run
      pulse_start();
      for (int i = 1; i <= 4; i++) send(i * 10, 0);
      valid_dst = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("rst_ready", ready_dst, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_mis", mismatch, 0);
      chk("rst_rx", rx_count, 0);
      chk("rst_err", err_count, 0);
      chk("rst_last", last_data, 0);
      chk("rst_sum", checksum, 0);
      @(negedge clk_dst);
      rst_n = 1'b1;
      @(negedge clk_dst);
      pulse_start();
      for (int i = 1; i <= 10; i++) send(i * 10, $urandom_range(0, 1));
      valid_dst = 1'b0;
      @(negedge clk_dst);
      check_end("after_rst", 10, 0, 16'h0226);

      // start mid-run ignored, idle valid
      pulse_start();
      for (int i = 1; i <= 5; i++) send(i * 10, 0);
      valid_dst = 1'b0;
      pulse_start();
      repeat (20) @(negedge clk_dst);
      chk("idle_rx", rx_count, 5);
      chk("idle_busy", busy, 1);
      chk("idle_sum", checksum, 150);
      for (int i = 6; i <= 10; i++) send(i * 10, 0);
      valid_dst = 1'b0;
      @(negedge clk_dst);
      check_end("midstart", 10, 0, 16'h0226);

      // random runs with occasional corruption
      for (int r = 0; r < 4; r++) begin
         pulse_start();
         for (int i = 0; i < 10; i++) begin
            d = exp_word(i);
            if ($urandom_range(0, 3) == 0) d = int'($urandom_range(0, 255));
            send(d, $urandom_range(0, 3));
         end
         valid_dst = 1'b0;
         @(negedge clk_dst);
         chk("rand_done", done, 1);
         chk("rand_rx", rx_count, 10);
      end

      // wrapping expected sequence on second instance
      start_w = 1'b1;
      @(negedge clk_dst);
      start_w = 1'b0;
      foreach (ws[i]) begin
         valid_w = 1'b1;
         data_w = 8'(ws[i]);
         n = 0;
         while (!ready_w && n < 20) begin
            @(negedge clk_dst);
            n++;
         end
         if (!ready_w) chk("wrap_timeout", ready_w, 1);
         @(negedge clk_dst);
      end
      valid_w = 1'b0;
      @(negedge clk_dst);
      chk("wrap_err", err_w, 0);
      chk("wrap_rx", rx_w, 3);
      chk("wrap_sum", sum_w, 268);
      chk("wrap_done", done_w, 1);
      chk("wrap_last", last_w, 14);
      chk("wrap_busy", busy_w, 0);
      chk("wrap_ready", ready_w, 0);
      chk("wrap_mis", mis_w, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
